// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter/sequencer.
package alu_arb_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StBusy,
        StResp
    } state_e;

    // ALU function encodings carried on funct3.
    localparam logic [2:0] Funct3AddSub = 3'd0;
    localparam logic [2:0] Funct3Sll    = 3'd1;
    localparam logic [2:0] Funct3Slt    = 3'd2;
    localparam logic [2:0] Funct3Sltu   = 3'd3;
    localparam logic [2:0] Funct3Xor    = 3'd4;
    localparam logic [2:0] Funct3Sr     = 3'd5;
    localparam logic [2:0] Funct3Or     = 3'd6;
    localparam logic [2:0] Funct3And    = 3'd7;

    // Width of the BUSY watchdog counter.
    localparam int unsigned TimeoutCntW = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; purely combinational.
module rr_arb2 (
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       last_grant_i,  // index of the requester granted last
    output logic [1:0] grant_o        // one-hot
);

    // On a tie, favour the requester that was not granted last.
    always_comb begin
        grant_o = 2'b00;
        if (valid0_i && valid1_i) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end else if (valid0_i) begin
            grant_o = 2'b01;
        end else if (valid1_i) begin
            grant_o = 2'b10;
        end
    end

endmodule

// File: rtl/alu_arb.sv
// Arbiter and sequencer for the shared multi-cycle ALU.
// Two clients, round-robin grant, registered operands, one-cycle response pulse.
// Optional BUSY watchdog built when ALU_ARB_TIMEOUT_EN is defined.
module alu_arb
    import alu_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,          // asynchronous, active-low

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_arg1_i,
    input  logic [31:0] req0_arg2_i,
    input  logic [2:0]  req0_funct3_i,
    input  logic        req0_subSr_i,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_arg1_i,
    input  logic [31:0] req1_arg2_i,
    input  logic [2:0]  req1_funct3_i,
    input  logic        req1_subSr_i,

    output logic        rsp0_valid_o,
    output logic        rsp1_valid_o,
    output logic [31:0] rspRes_o,
    output logic        rspErr_o,

    output logic [31:0] aluArg1_o,
    output logic [31:0] aluArg2_o,
    output logic [2:0]  aluFunct3_o,
    output logic        aluSubSr_o,
    output logic        aluRun_o,
    input  logic [31:0] aluRes_i,
    input  logic        aluDone_i
);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic [31:0] arg1_q, arg1_d;
    logic [31:0] arg2_q, arg2_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        subsr_q, subsr_d;
    logic        run_q, run_d;
    logic [31:0] res_q, res_d;
    logic [1:0]  grant;
    logic        tmo_hit;

    rr_arb2 u_rr_arb2 (
        .valid0_i     (req0_valid_i),
        .valid1_i     (req1_valid_i),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    // Next-state, capture and ready logic for the sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        arg1_d       = arg1_q;
        arg2_d       = arg2_q;
        funct3_d     = funct3_q;
        subsr_d      = subsr_q;
        run_d        = run_q;
        res_d        = res_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Gate with reset so ready stays low while reset is held.
                req0_ready_o = grant[0] & rst_i;
                req1_ready_o = grant[1] & rst_i;
                if (grant != 2'b00) begin
                    owner_d      = grant[1];
                    last_grant_d = grant[1];
                    arg1_d       = grant[1] ? req1_arg1_i   : req0_arg1_i;
                    arg2_d       = grant[1] ? req1_arg2_i   : req0_arg2_i;
                    funct3_d     = grant[1] ? req1_funct3_i : req0_funct3_i;
                    subsr_d      = grant[1] ? req1_subSr_i  : req0_subSr_i;
                    run_d        = 1'b1;
                    state_d      = StLaunch;
                end
            end
            StLaunch: begin
                // Done is ignored here so a stale done is never taken.
                state_d = StBusy;
            end
            StBusy: begin
                if (aluDone_i || tmo_hit) begin
                    res_d   = aluDone_i ? aluRes_i : 32'd0;
                    run_d   = 1'b0;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            arg1_q       <= '0;
            arg2_q       <= '0;
            funct3_q     <= '0;
            subsr_q      <= 1'b0;
            run_q        <= 1'b0;
            res_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            arg1_q       <= arg1_d;
            arg2_q       <= arg2_d;
            funct3_q     <= funct3_d;
            subsr_q      <= subsr_d;
            run_q        <= run_d;
            res_q        <= res_d;
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    localparam logic [TimeoutCntW-1:0] TimeoutLast = TimeoutCntW'(TIMEOUT_CYCLES - 1);

    logic [TimeoutCntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                   err_q, err_d;

    // Hit on the TIMEOUT_CYCLES-th BUSY cycle; done in that cycle still wins.
    assign tmo_hit = (state_q == StBusy) && (tmo_cnt_q == TimeoutLast);

    // Watchdog count and error flag for the response.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        err_d     = err_q;
        if (state_q == StLaunch) begin
            tmo_cnt_d = '0;
        end else if (state_q == StBusy) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (aluDone_i) begin
                err_d = 1'b0;
            end else if (tmo_hit) begin
                err_d = 1'b1;
            end
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign rspErr_o = err_q;
`else
    // No watchdog: BUSY waits for done indefinitely.
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (TIMEOUT_CYCLES == 0);
    assign tmo_hit  = 1'b0;
    assign rspErr_o = 1'b0;
`endif

    assign rsp0_valid_o = (state_q == StResp) && !owner_q;
    assign rsp1_valid_o = (state_q == StResp) &&  owner_q;
    assign rspRes_o     = res_q;
    assign aluArg1_o    = arg1_q;
    assign aluArg2_o    = arg2_q;
    assign aluFunct3_o  = funct3_q;
    assign aluSubSr_o   = subsr_q;
    assign aluRun_o     = run_q;

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb with a behavioural ALU and transaction scoreboard.
module tb_alu_arb;
    import alu_arb_pkg::*;

    localparam int unsigned TmoCycles = 16;

    typedef struct {
        int          owner;
        int          cyc;
        logic [31:0] exp;
    } hs_t;

    typedef struct {
        int          owner;
        int          cyc;
        logic [31:0] res;
        logic        err;
        logic        run;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    logic [2:0]  req_f [2];
    logic        req_s [2];
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_res;
    logic        rsp_err;
    logic [31:0] alu_arg1, alu_arg2, alu_res;
    logic [2:0]  alu_f3;
    logic        alu_subsr, alu_run, alu_done;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   alu_lat = 3;
    int   alu_cnt = 0;
    logic alu_done_m = 1'b0;
    logic alu_force = 1'b0;
    hs_t  hs_q[$];
    rsp_t rsp_q[$];

    always #5 clk = ~clk;

    alu_arb #(.TIMEOUT_CYCLES(TmoCycles)) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .req0_valid_i  (req_valid[0]),
        .req0_ready_o  (req_ready[0]),
        .req0_arg1_i   (req_a[0]),
        .req0_arg2_i   (req_b[0]),
        .req0_funct3_i (req_f[0]),
        .req0_subSr_i  (req_s[0]),
        .req1_valid_i  (req_valid[1]),
        .req1_ready_o  (req_ready[1]),
        .req1_arg1_i   (req_a[1]),
        .req1_arg2_i   (req_b[1]),
        .req1_funct3_i (req_f[1]),
        .req1_subSr_i  (req_s[1]),
        .rsp0_valid_o  (rsp_valid[0]),
        .rsp1_valid_o  (rsp_valid[1]),
        .rspRes_o      (rsp_res),
        .rspErr_o      (rsp_err),
        .aluArg1_o     (alu_arg1),
        .aluArg2_o     (alu_arg2),
        .aluFunct3_o   (alu_f3),
        .aluSubSr_o    (alu_subsr),
        .aluRun_o      (alu_run),
        .aluRes_i      (alu_res),
        .aluDone_i     (alu_done)
    );

    // Reference ALU semantics.
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f, input logic s);
        case (f)
            Funct3AddSub: return s ? a - b : a + b;
            Funct3Sll:    return a << b[4:0];
            Funct3Slt:    return {31'b0, $signed(a) < $signed(b)};
            Funct3Sltu:   return {31'b0, a < b};
            Funct3Xor:    return a ^ b;
            Funct3Sr:     return s ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            Funct3Or:     return a | b;
            default:      return a & b;
        endcase
    endfunction

    // ALU model: held in reset while run is low, done alu_lat cycles after run rises.
    assign alu_res  = alu_ref(alu_arg1, alu_arg2, alu_f3, alu_subsr);
    assign alu_done = alu_done_m | alu_force;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!alu_run) begin
            alu_cnt    <= 0;
            alu_done_m <= 1'b0;
        end else begin
            alu_cnt    <= alu_cnt + 1;
            alu_done_m <= (alu_lat != 0) && (alu_cnt + 1 == alu_lat);
        end
    end

    // Transaction monitor: handshakes and response pulses, sampled mid-cycle.
    always @(negedge clk) begin : mon
        hs_t  h;
        rsp_t r;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    h.owner = i;
                    h.cyc   = cyc;
                    h.exp   = alu_ref(req_a[i], req_b[i], req_f[i], req_s[i]);
                    hs_q.push_back(h);
                end
            end
            if (rsp_valid != 2'b00) begin
                r.owner = (rsp_valid == 2'b11) ? 2 : (rsp_valid[1] ? 1 : 0);
                r.cyc   = cyc;
                r.res   = rsp_res;
                r.err   = rsp_err;
                r.run   = alu_run;
                rsp_q.push_back(r);
            end
        end
    end

    task automatic drive_req(input int id, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] f, input logic s);
        req_a[id] = a;
        req_b[id] = b;
        req_f[id] = f;
        req_s[id] = s;
        req_valid[id] = 1'b1;
    endtask

    // Drop valid and garble operands: they only matter in the handshake cycle.
    task automatic scramble(input int id);
        req_valid[id] = 1'b0;
        req_a[id] = $urandom;
        req_b[id] = $urandom;
        req_f[id] = 3'($urandom_range(0, 7));
        req_s[id] = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_hs(input int budget, output hs_t h, output bit ok);
        ok = 1'b0;
        h.owner = -1;
        h.cyc = 0;
        h.exp = '0;
        for (int i = 0; i < budget; i++) begin
            if (hs_q.size() > 0) begin
                h = hs_q.pop_front();
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic wait_rsp(input int budget, output rsp_t r, output bit ok);
        ok = 1'b0;
        r.owner = -1;
        r.cyc = 0;
        r.res = '0;
        r.err = 1'b0;
        r.run = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rsp_q.size() > 0) begin
                r = rsp_q.pop_front();
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hs_q.delete();
        rsp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        for (int i = 0; i < 2; i++) begin
            req_a[i] = $urandom;
            req_b[i] = $urandom;
            req_f[i] = Funct3Add();
            req_s[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready: got %b want 00", req_ready);
        end
        checks++;
        if (alu_run !== 1'b0 || alu_arg1 !== 32'd0 || alu_arg2 !== 32'd0) begin
            failures++;
            $display("FAIL reset_alu: run=%b a1=%h a2=%h want 0", alu_run, alu_arg1, alu_arg2);
        end
        checks++;
        if (alu_f3 !== 3'd0 || alu_subsr !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl: f3=%0d sub=%b want 0", alu_f3, alu_subsr);
        end
        checks++;
        if (rsp_valid !== 2'b00 || rsp_res !== 32'd0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp: v=%b res=%h err=%b want 0", rsp_valid, rsp_res, rsp_err);
        end
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Named alias for the add encoding used by the reset stimulus.
    function automatic logic [2:0] Funct3Add();
        return Funct3AddSub;
    endfunction

    task automatic test_ops();
        hs_t h;
        rsp_t r;
        bit ok;
        int id, lat;
        logic [31:0] a, b;
        logic [2:0] f;
        logic s;
        for (int n = 0; n < 26; n++) begin
            if (n == 0) begin
                id = 0; a = 32'd5; b = 32'd7; f = Funct3AddSub; s = 1'b0; lat = 3;
            end else if (n == 1) begin
                id = 1; a = 32'd3; b = 32'd5; f = Funct3AddSub; s = 1'b1; lat = 3;
            end else begin
                id = int'($urandom_range(0, 1));
                a = $urandom;
                b = $urandom;
                f = 3'($urandom_range(0, 7));
                s = 1'($urandom_range(0, 1));
                lat = int'($urandom_range(1, 6));
            end
            @(posedge clk);
            #1;
            alu_lat = lat;
            drive_req(id, a, b, f, s);
            wait_hs(50, h, ok);
            #1;
            scramble(id);
            checks++;
            if (!ok || h.owner != id) begin
                failures++;
                $display("FAIL op%0d_grant: got %0d want %0d", n, h.owner, id);
            end
            wait_rsp(lat + 20, r, ok);
            checks++;
            if (!ok || r.owner != id) begin
                failures++;
                $display("FAIL op%0d_rsp_owner: got %0d want %0d", n, r.owner, id);
            end
            checks++;
            if (r.res !== h.exp || r.err !== 1'b0) begin
                failures++;
                $display("FAIL op%0d_result: got %h err=%b want %h err=0", n, r.res, r.err, h.exp);
            end
            checks++;
            if (r.cyc != h.cyc + 2 + lat || r.run !== 1'b0) begin
                failures++;
                $display("FAIL op%0d_timing: rsp cycle %0d run=%b want %0d run=0",
                         n, r.cyc, r.run, h.cyc + 2 + lat);
            end
            if (n == 0) begin
                checks++;
                if (r.res !== 32'd12) begin
                    failures++;
                    $display("FAIL add_5_7: got %h want 0000000c", r.res);
                end
            end else if (n == 1) begin
                checks++;
                if (r.res !== 32'hFFFF_FFFE) begin
                    failures++;
                    $display("FAIL sub_3_5: got %h want fffffffe", r.res);
                end
            end
            repeat (2) @(posedge clk);
            checks++;
            if (rsp_q.size() != 0) begin
                failures++;
                $display("FAIL op%0d_single_pulse: got %0d extra pulses want 0", n, rsp_q.size());
                rsp_q.delete();
            end
        end
    endtask

    task automatic test_tie();
        hs_t h;
        rsp_t r;
        bit ok;
        int prev_rsp;
        apply_reset();
        alu_lat = int'($urandom_range(1, 4));
        @(posedge clk);
        #1;
        drive_req(0, $urandom, $urandom, Funct3Xor, 1'b0);
        drive_req(1, $urandom, $urandom, Funct3Or, 1'b0);
        prev_rsp = -1;
        for (int k = 0; k < 4; k++) begin
            wait_hs(50, h, ok);
            checks++;
            if (!ok || h.owner != k % 2) begin
                failures++;
                $display("FAIL tie_grant%0d: got %0d want %0d", k, h.owner, k % 2);
            end
            if (ok && prev_rsp >= 0) begin
                checks++;
                if (h.cyc != prev_rsp + 1) begin
                    failures++;
                    $display("FAIL b2b_gap%0d: got cycle %0d want %0d", k, h.cyc, prev_rsp + 1);
                end
            end
            wait_rsp(30, r, ok);
            checks++;
            if (!ok || r.owner != k % 2 || r.res !== h.exp) begin
                failures++;
                $display("FAIL tie_rsp%0d: got owner %0d res %h want owner %0d res %h",
                         k, r.owner, r.res, k % 2, h.exp);
            end
            prev_rsp = r.cyc;
        end
        #1;
        req_valid = 2'b00;
        repeat (10) @(posedge clk);
        checks++;
        if (hs_q.size() != 0 || rsp_q.size() != 0) begin
            failures++;
            $display("FAIL tie_extra: got %0d hs %0d rsp want 0 0", hs_q.size(), rsp_q.size());
            hs_q.delete();
            rsp_q.delete();
        end
    endtask

    task automatic test_busy_holdoff();
        hs_t h0, h1;
        rsp_t r;
        bit ok, seen;
        int resp_c;
        logic [31:0] a0;
        alu_lat = 6;
        @(posedge clk);
        #1;
        a0 = $urandom;
        drive_req(0, a0, $urandom, Funct3AddSub, 1'b0);
        wait_hs(50, h0, ok);
        #1;
        scramble(0);
        checks++;
        if (!ok || h0.owner != 0) begin
            failures++;
            $display("FAIL holdoff_grant0: got %0d want 0", h0.owner);
        end
        @(posedge clk);
        #1;
        drive_req(1, $urandom, $urandom, Funct3Sltu, 1'b0);
        seen = 1'b0;
        resp_c = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready[1] !== 1'b0) begin
                failures++;
                $display("FAIL holdoff_ready: got %b want 0", req_ready[1]);
            end
            checks++;
            if (alu_arg1 !== a0) begin
                failures++;
                $display("FAIL holdoff_arg1: got %h want %h", alu_arg1, a0);
            end
            if (rsp_valid[0]) begin
                seen = 1'b1;
                resp_c = cyc;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL holdoff_rsp0: got no pulse want pulse");
        end
        wait_rsp(5, r, ok);
        checks++;
        if (!ok || r.owner != 0 || r.res !== h0.exp) begin
            failures++;
            $display("FAIL holdoff_rsp0_data: got %0d/%h want 0/%h", r.owner, r.res, h0.exp);
        end
        wait_hs(5, h1, ok);
        #1;
        scramble(1);
        checks++;
        if (!ok || h1.owner != 1 || h1.cyc != resp_c + 1) begin
            failures++;
            $display("FAIL holdoff_grant1: got owner %0d cycle %0d want 1 cycle %0d",
                     h1.owner, h1.cyc, resp_c + 1);
        end
        wait_rsp(30, r, ok);
        checks++;
        if (!ok || r.owner != 1 || r.res !== h1.exp) begin
            failures++;
            $display("FAIL holdoff_rsp1: got %0d/%h want 1/%h", r.owner, r.res, h1.exp);
        end
    endtask

    task automatic test_stale_done();
        hs_t h;
        rsp_t r;
        bit ok;
        @(posedge clk);
        #1;
        alu_force = 1'b1;
        @(posedge clk);
        #1;
        alu_force = 1'b0;
        repeat (4) @(posedge clk);
        checks++;
        if (rsp_q.size() != 0 || hs_q.size() != 0) begin
            failures++;
            $display("FAIL idle_done: got %0d pulses want 0", rsp_q.size());
            rsp_q.delete();
        end
        alu_lat = 4;
        @(posedge clk);
        #1;
        drive_req(1, $urandom, $urandom, Funct3Sll, 1'b0);
        wait_hs(50, h, ok);
        #1;
        scramble(1);
        alu_force = 1'b1;
        @(posedge clk);
        #1;
        alu_force = 1'b0;
        checks++;
        if (!ok || h.owner != 1) begin
            failures++;
            $display("FAIL stale_grant: got %0d want 1", h.owner);
        end
        wait_rsp(30, r, ok);
        checks++;
        if (!ok || r.owner != 1 || r.res !== h.exp || r.cyc != h.cyc + 6) begin
            failures++;
            $display("FAIL stale_launch_done: got %0d/%h cycle %0d want 1/%h cycle %0d",
                     r.owner, r.res, r.cyc, h.exp, h.cyc + 6);
        end
    endtask

    task automatic test_reset_abort();
        hs_t h;
        rsp_t r;
        bit ok;
        alu_lat = 10;
        @(posedge clk);
        #1;
        drive_req(0, $urandom, $urandom, Funct3And, 1'b0);
        wait_hs(50, h, ok);
        #1;
        scramble(0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (!ok || alu_run !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy: got run=%b want 1", alu_run);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (alu_run !== 1'b0 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
            failures++;
            $display("FAIL abort_async: got run=%b rdy=%b rsp=%b want 0",
                     alu_run, req_ready, rsp_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        checks++;
        if (rsp_q.size() != 0) begin
            failures++;
            $display("FAIL abort_no_rsp: got %0d pulses want 0", rsp_q.size());
            rsp_q.delete();
        end
        #1;
        alu_lat = 2;
        drive_req(0, $urandom, $urandom, Funct3Or, 1'b0);
        drive_req(1, $urandom, $urandom, Funct3Or, 1'b0);
        wait_hs(20, h, ok);
        #1;
        req_valid = 2'b00;
        checks++;
        if (!ok || h.owner != 0) begin
            failures++;
            $display("FAIL abort_first_tie: got %0d want 0", h.owner);
        end
        wait_rsp(30, r, ok);
        checks++;
        if (!ok || r.owner != 0 || r.res !== h.exp) begin
            failures++;
            $display("FAIL abort_rsp: got %0d/%h want 0/%h", r.owner, r.res, h.exp);
        end
    endtask

`ifdef ALU_ARB_TIMEOUT_EN
    task automatic test_timeout();
        hs_t h;
        rsp_t r;
        bit ok;
        int lats [3];
        lats[0] = 0;
        lats[1] = int'(TmoCycles);
        lats[2] = int'(TmoCycles) + 1;
        for (int k = 0; k < 3; k++) begin
            alu_lat = lats[k];
            @(posedge clk);
            #1;
            drive_req(k % 2, $urandom, $urandom, Funct3Xor, 1'b0);
            wait_hs(50, h, ok);
            #1;
            scramble(k % 2);
            wait_rsp(int'(TmoCycles) + 20, r, ok);
            checks++;
            if (!ok || r.owner != k % 2 || r.cyc != h.cyc + 2 + int'(TmoCycles)) begin
                failures++;
                $display("FAIL tmo%0d_timing: got owner %0d cycle %0d want %0d cycle %0d",
                         k, r.owner, r.cyc, k % 2, h.cyc + 2 + int'(TmoCycles));
            end
            checks++;
            if (k == 1 && (r.err !== 1'b0 || r.res !== h.exp)) begin
                failures++;
                $display("FAIL tmo_done_wins: got err=%b res=%h want 0/%h", r.err, r.res, h.exp);
            end else if (k != 1 && (r.err !== 1'b1 || r.res !== 32'd0)) begin
                failures++;
                $display("FAIL tmo%0d_err: got err=%b res=%h want 1/0", k, r.err, r.res);
            end
            repeat (3) @(posedge clk);
            checks++;
            if (rsp_q.size() != 0) begin
                failures++;
                $display("FAIL tmo%0d_late_done: got %0d pulses want 0", k, rsp_q.size());
                rsp_q.delete();
            end
        end
    endtask
`else
    task automatic test_no_timeout();
        hs_t h;
        rsp_t r;
        bit ok;
        alu_lat = 3 * int'(TmoCycles);
        @(posedge clk);
        #1;
        drive_req(1, $urandom, $urandom, Funct3Sr, 1'b1);
        wait_hs(50, h, ok);
        #1;
        scramble(1);
        wait_rsp(alu_lat + 20, r, ok);
        checks++;
        if (!ok || r.owner != 1 || r.cyc != h.cyc + 2 + alu_lat) begin
            failures++;
            $display("FAIL long_wait: got owner %0d cycle %0d want 1 cycle %0d",
                     r.owner, r.cyc, h.cyc + 2 + alu_lat);
        end
        checks++;
        if (r.err !== 1'b0 || r.res !== h.exp) begin
            failures++;
            $display("FAIL long_wait_data: got err=%b res=%h want 0/%h", r.err, r.res, h.exp);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ops();
        test_tie();
        test_busy_holdoff();
        test_stale_done();
        test_reset_abort();
`ifdef ALU_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arb.md
# alu_arb

Two-requester arbiter and sequencer for the shared multi-cycle ALU. It accepts operations from two clients over valid/ready handshakes and grants the ALU round-robin. It launches the granted operation with registered operands, waits for the ALU's `done_o`, and returns the result to the owning client as a one-cycle response pulse. It sits between the execute and address-generation stages and the single `alu` instance.

## Interface
- `TIMEOUT_CYCLES`, default 64: watchdog limit in BUSY cycles; used only when `ALU_ARB_TIMEOUT_EN` is defined; legal range 2..255.
- `clk_i` in 1: the only clock; all flops are on its rising edge.
- `rst_i` in 1: one clock; reset is asynchronous and active-low.
- `req0_valid_i` / `req1_valid_i` in 1: the client has an operation pending.
- `req0_ready_o` / `req1_ready_o` out 1: operation accepted this cycle when ready and valid are both high.
- `req0_arg1_i`, `req0_arg2_i` / `req1_arg1_i`, `req1_arg2_i` in 32: operands.
- `req0_funct3_i` / `req1_funct3_i` in 3: ALU function.
- `req0_subSr_i` / `req1_subSr_i` in 1: sub / arithmetic-shift select.
- `rsp0_valid_o` / `rsp1_valid_o` out 1: one-cycle response pulse to the owning client.
- `rspRes_o` out 32: result; valid only while a `rspN_valid_o` is high.
- `rspErr_o` out 1: timeout flag; valid only while a `rspN_valid_o` is high.
- `aluArg1_o`, `aluArg2_o` out 32: registered operands to the ALU.
- `aluFunct3_o` out 3, `aluSubSr_o` out 1: registered controls to the ALU.
- `aluRun_o` out 1: level signal. The ALU wrapper holds the ALU in reset while this is low; its rising edge starts an operation.
- `aluRes_i` in 32, `aluDone_i` in 1: ALU result and done.

## Operation
- FSM states are IDLE, LAUNCH, BUSY and RESP.
- **IDLE**
  - `reqN_ready_o` is high for the granted requester only, combinationally from the valids.
  - Grant rule: if only one requester is valid, it is granted. If both are valid, the requester not granted last is granted.
  - On a handshake: operands and controls are captured into the `alu*_o` registers, the owner is latched, `lastGrant` is updated, and the FSM moves to LAUNCH.
- **LAUNCH** (exactly one cycle)
  - `aluRun_o` is 1.
  - `aluDone_i` is ignored, so a stale done from the previous operation is never taken.
  - Next state is BUSY.
- **BUSY**
  - `aluRun_o` is 1.
  - When `aluDone_i` is 1, `aluRes_i` is captured into the result register and the FSM moves to RESP.
- **RESP** (exactly one cycle)
  - `rspN_valid_o` is 1 for the owner only, and `aluRun_o` is 0.
  - Next state is IDLE.
- Both ready outputs are 0 in every state except IDLE. Client operands need to be valid only in the handshake cycle.
- Operands and controls on the `alu*_o` ports stay stable from LAUNCH through RESP.
- The ALU is not modified. Result width is 32 bits and wrap-around is whatever the ALU produces; no arithmetic is done here.

## Timing
- Reset values:
  - state = IDLE, `lastGrant` = 1, so req0 wins the first tie.
  - All `alu*_o` outputs are 0, including `aluRun_o`.
  - `rspRes_o` = 0, `rspErr_o` = 0, both `rspN_valid_o` = 0, both `reqN_ready_o` = 0 while in reset.
- Latency: handshake in cycle N, LAUNCH in N+1, BUSY from N+2. If the ALU raises done in cycle D ≥ N+2, the response pulse is in cycle D+1 and the next handshake is possible in cycle D+2.
- Back-to-back: a requester that holds valid high through its own response loses the next tie when the other requester is valid.
- Reset mid-operation: the FSM returns to IDLE and `aluRun_o` falls asynchronously. No response is generated for the aborted operation, and the ALU is reset through the wrapper.
- A `aluDone_i` pulse outside BUSY is ignored.

## Configuration
- Macro: `ALU_ARB_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter clears on entry to BUSY and increments once per BUSY cycle.
  - When it reaches `TIMEOUT_CYCLES` without done, the FSM moves to RESP with `rspErr_o` = 1 and `rspRes_o` = 0.
  - Done and timeout in the same cycle: done wins and `rspErr_o` = 0.
- Undefined: no counter is built, `rspErr_o` is tied to 0, and BUSY waits for done indefinitely.

## Structure
- Package `alu_arb_pkg`:
  - state enum {IDLE, LAUNCH, BUSY, RESP};
  - funct3 constants ADD_SUB=0, SLL=1, SLT=2, SLTU=3, XOR=4, SR=5, OR=6, AND=7;
  - timeout counter width constant (8).
- One sub-module, `rr_arb2`:
  - inputs: two valids, `lastGrant`;
  - outputs: one-hot grant;
  - purely combinational.
- The `lastGrant` flop lives in `alu_arb`.

## Test plan
- **Single request:** req0 ADD of 5 and 7 (funct3=0, subSr=0), ALU model raises done 3 cycles after `aluRun_o` rises → `rsp0_valid_o` pulses once with `rspRes_o` = 12. `rsp1_valid_o` never asserts.
- **Subtract:** req1 with arg1=3, arg2=5, funct3=0, subSr=1 → `rsp1_valid_o` pulses with `rspRes_o` = 0xFFFFFFFE.
- **Tie and alternation:** both valids held high from reset release → grant order is 0,1,0,1. Each response goes only to its owner, with the correct result per operation.
- **Busy hold-off:** req1 goes valid during req0's BUSY → `req1_ready_o` stays 0 until IDLE, then the handshake happens. `aluArg1_o` is unchanged throughout req0's operation.
- **Reset abort:** `rst_i` is driven low in the second BUSY cycle → `aluRun_o` goes to 0 within the same cycle and no response pulse follows. After release, req0 wins the first tie.
- **Timeout:** `ALU_ARB_TIMEOUT_EN` defined, `TIMEOUT_CYCLES` = 16, ALU model never raises done → the response pulse arrives 16 BUSY cycles after entry, with `rspErr_o` = 1 and `rspRes_o` = 0.
